// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch path.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd8;
  localparam int unsigned ROM_AW    = 10;

  // One fetched instruction pair as presented to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic        slot2_valid;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{
    pc:          32'h0000_0000,
    instr1:      NOP_INSTR,
    instr2:      NOP_INSTR,
    slot2_valid: 1'b0
  };

endpackage

// File: rtl/fetch_queue.sv
// Shift-register FIFO of instruction pairs; the head entry is always a register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned CW    = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  ent [QDEPTH];
  logic [CW-1:0] cnt;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] wr_idx;

  // Handshake qualification and write slot after a same-cycle pop
  always_comb begin
    pop_ok  = pop & (cnt != '0);
    push_ok = push & ((cnt != CW'(QDEPTH)) | pop_ok);
    wr_idx  = cnt - CW'(pop_ok);
  end

  // Storage: flush beats push, pop shifts toward slot 0, push lands behind the tail
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) ent[i] <= EMPTY_ENTRY;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < int'(QDEPTH) - 1; i++) ent[i] <= ent[i+1];
      end
      for (int i = 0; i < int'(QDEPTH); i++) begin
        if (push_ok && (CW'(i) == wr_idx)) ent[i] <= din;
      end
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign head  = ent[0];
  assign count = cnt;
  assign full  = (cnt == CW'(QDEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: owns the PC, reads 2 ROM words per cycle,
// absorbs the 1-cycle ROM latency and queues pairs toward decode.
module fetch_ctrl
  import fetch_pkg::fetch_entry_t;
  import fetch_pkg::NOP_INSTR;
  import fetch_pkg::PC_STEP;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned ROM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr1,
  output logic [31:0]       out_instr2,
  output logic              out_slot2_valid
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   req_pc;
  logic          issue;
  logic          push;
  logic          slot2;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;

  // Request PC, issue decision and ROM address; redirect overrides the sequential PC
  always_comb begin
    req_pc = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : fetch_pc;
    // Reserve a slot for the in-flight read so a full queue can never overflow
    issue  = redirect_valid |
             (!q_full && (((CW+1)'(q_count) + (CW+1)'(inflight)) < (CW+1)'(QDEPTH)));
    if (rst) rom_addr = RESET_PC[ROM_AW+1:2];
    else     rom_addr = req_pc[ROM_AW+1:2];
  end

  // Returning ROM pair; the last ROM word has no successor so slot 2 becomes a NOP
  always_comb begin
    slot2      = (inflight_pc[ROM_AW+1:2] != '1);
    push       = inflight & ~redirect_valid;
    push_entry = '{
      pc:          inflight_pc,
      instr1:      rom_instr1,
      instr2:      slot2 ? rom_instr2 : NOP_INSTR,
      slot2_valid: slot2
    };
  end

  // Fetch PC and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (issue) begin
      fetch_pc    <= req_pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= req_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (out_ready),
    .head  (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign out_valid       = ~q_empty;
  assign out_pc          = head.pc;
  assign out_instr1      = head.instr1;
  assign out_instr2      = head.instr2;
  assign out_slot2_valid = head.slot2_valid;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Dual-issue instruction fetch sequencer that drives the instruction ROM.
- Owns the fetch PC and issues one 2-word ROM read per cycle.
- Absorbs the ROM's 1-cycle synchronous read latency.
- Buffers returned instruction pairs in a small queue toward decode; handles backpressure, branch/JAL redirect and the end-of-ROM boundary.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- QDEPTH, 4, instruction-pair queue entries (power of 2, >=2)
- ROM_AW, 10, ROM word-address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rom_addr  out  ROM_AW  word address to ROM (PC[ROM_AW+1:2])
- rom_instr1  in  32  ROM word at rom_addr, valid 1 cycle after address
- rom_instr2  in  32  ROM word at rom_addr+1, same timing
- redirect_valid  in  1  branch/JAL taken; flush and restart
- redirect_pc  in  32  new fetch PC, word-aligned (bits[1:0] ignored)
- out_valid  out  1  queue head holds a pair
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of out_instr1; out_instr2 is at out_pc+4
- out_instr1  out  32  first instruction
- out_instr2  out  32  second instruction (NOP when slot2 invalid)
- out_slot2_valid  out  1  out_instr2 is a real instruction

Behaviour:
- Reset (sync, rst=1 at posedge):
  - fetch_pc <= RESET_PC; queue emptied; inflight <= 0.
  - Outputs during and after reset until first data: out_valid=0, out_pc=0, out_instr1/2=32'h00000013, out_slot2_valid=0.
  - rom_addr = RESET_PC[11:2] while rst=1.
  - Reset mid-stream discards queue and inflight data; ROM output in the cycle after reset is ignored, so the ROM's uninitialised/NOP power-up value is never consumed.
- rom_addr is combinational: redirect_valid ? redirect_pc[11:2] : fetch_pc[11:2].
- Issue condition: issue = redirect_valid | (count + inflight < QDEPTH).
  - count is the current occupancy, not reduced by a same-cycle pop. This makes the conservative reservation overflow-free.
- On issue at cycle T:
  - req_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : fetch_pc
  - fetch_pc <= req_pc + 8; inflight <= 1; inflight_pc <= req_pc.
- No issue: fetch_pc holds, inflight <= 0.
- Return at T+1: if inflight=1 and no redirect this cycle, push {inflight_pc, rom_instr1, rom_instr2, slot2_valid} into the queue.
  - slot2_valid = (inflight_pc[11:2] != all-ones). Word 1023 has no successor, so instr2 is forced to 32'h00000013 and slot2_valid=0.
- Pop: out_valid & out_ready. Head advances; push and pop in the same cycle are both honoured.
- Queue outputs are registered head contents (no bypass). Fill latency from issue to out_valid is 2 cycles.
- Steady state with out_ready=1: one pair per cycle; out_pc increments by 8.
- Redirect (priority over everything except rst), in the same cycle:
  - Queue cleared (including any same-cycle pop; the pop still counts as accepted by decode).
  - Returning ROM data dropped.
  - New request issued at redirect_pc.
  - First new pair appears at out_valid on T+2.
  - Back-to-back redirects: each one supersedes the previous; only the last survives.
- Backpressure: out_ready=0 holds all outputs stable. Issue stops once count + inflight = QDEPTH; no instruction is lost or duplicated.
- PC wrap: fetch_pc is a full 32-bit counter (mod 2^32); rom_addr uses bits[11:2], so addresses wrap modulo the 4 KiB ROM.
- Unaligned redirect_pc[2]=1 is legal: the pair is words N and N+1.

Decomposition:
- fetch_pkg:
  - NOP_INSTR = 32'h00000013
  - PC_STEP = 8
  - ROM_AW
  - fetch_entry_t = {pc[31:0], instr1[31:0], instr2[31:0], slot2_valid}
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth QDEPTH.
  - Ports: push, pop, flush, count, full/empty; registered head outputs.
  - Flush has priority over push.

Test Plan:
- Reset then release with out_ready=1:
  - rom_addr = 0 during reset.
  - First out_valid 2 cycles after release: out_pc=0, instr1=00100293, instr2=00200313.
  - Next cycle: out_pc=8, 00300393/00400413.
  - One pair per cycle after that; no bubbles.
- Backpressure: out_ready=0 for 8 cycles from steady state.
  - Count saturates at 4 and rom_addr freezes.
  - On release: pairs for pc 0x00,0x08,0x10,0x18,... in order; no gaps or duplicates.
- Redirect to 0x24 while the queue is full:
  - All old entries vanish next cycle (out_valid=0).
  - At T+2: out_pc=0x24, instr1=rom[9]=00950733, instr2=rom[10]=00b607b3.
- Redirect to 0xFFC:
  - Pair has out_slot2_valid=0, instr2=00000013.
  - Next pair out_pc=0x1004 with rom_addr=1.
- Redirect asserted on consecutive cycles to 0x40 then 0x80:
  - Only the 0x80 stream appears.
  - No 0x40 or pre-redirect pair is ever presented.
- rst asserted for 1 cycle mid-stream with a full queue:
  - out_valid=0 the next cycle; rom_addr=0 during reset.
  - Restart at pc 0 with the same sequence as the first scenario.
